// File: rtl/mbe_final_adder_seq.sv
// mbe_final_adder_seq
//   Final carry-propagate adder behind the MBE Dadda tree. It adds the two reduced
//   rows CHUNK bits per cycle and keeps the carry in a register between chunks.
//   It takes NCHUNK cycles to form p = (a + b) mod 2^WIDTH.
//   Transfers use valid/ready handshakes on both sides. Only one transaction is in
//   flight at a time.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   a_i/b_i rows are valid
//   in_ready_o   block can accept a new pair of rows
//   a_i, b_i     reduced rows from the Dadda tree (WIDTH bits)
//   out_valid_o  p_o/cout_o hold a finished sum
//   out_ready_i  downstream takes the sum
//   p_o          (a + b) mod 2^WIDTH
//   cout_o       carry out of bit WIDTH-1 (informational)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a pair of rows; in_ready high once out of reset
// ADD   | adding one chunk per cycle, LSB chunk first
// DONE  | sum valid and held until the downstream takes it

module mbe_final_adder_seq #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] p_o,
  output logic             cout_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $fatal(1, "mbe_final_adder_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              armed_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  p_q, p_d;
  logic              carry_q;
  logic              cout_q;
  logic [IDXW-1:0]   idx_q;
  logic [CHUNK:0]    sum;
  logic              accept;
  logic              last;

  assign accept = in_valid_i & in_ready_o;
  assign last   = (idx_q == IDXW'(NCHUNK - 1));

  // One chunk of the ripple: {carry, s} = a_chunk + b_chunk + carry_in.
  always_comb begin
    sum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
        + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
        + {{CHUNK{1'b0}}, carry_q};
    p_d = p_q;
    p_d[idx_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)      state_d = S_ADD;
      S_ADD:   if (last)        state_d = S_DONE;
      S_DONE:  if (out_ready_i) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // armed_q holds in_ready low through reset and until the first clock edge after release.
  always_comb begin
    in_ready_o  = armed_q && (state_q == S_IDLE);
    out_valid_o = (state_q == S_DONE);
    p_o         = p_q;
    cout_o      = cout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        a_q     <= a_i;
        b_q     <= b_i;
        carry_q <= 1'b0;
        idx_q   <= '0;
      end else if (state_q == S_ADD) begin
        p_q     <= p_d;
        carry_q <= sum[CHUNK];
        if (last) begin
          cout_q <= sum[CHUNK];
          idx_q  <= '0;
        end else begin
          idx_q  <= idx_q + IDXW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mbe_final_adder_seq.sv
module tb_mbe_final_adder_seq;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] p;
  logic         cout;

  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic [W-1:0] a1 = '0, b1 = '0;
  logic         out_valid1;
  logic         out_ready1 = 1'b1;
  logic [W-1:0] p1;
  logic         cout1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mbe_final_adder_seq #(.WIDTH(W), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .p_o(p), .cout_o(cout)
  );

  mbe_final_adder_seq #(.WIDTH(W), .CHUNK(24)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid1), .in_ready_o(in_ready1),
    .a_i(a1), .b_i(b1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1),
    .p_o(p1), .cout_o(cout1)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         c;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offers one pair of rows on the 8-bit-chunk instance, waits for out_valid and
  // returns the sum. Returns at the falling edge where out_valid is first seen.
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int exp_lat,
                        output logic [W-1:0] rp, output logic rc);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb_;
    @(posedge clk);
    last_acc = cyc;
    #1 in_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_lat);
    check("out_valid", {31'd0, out_valid}, 32'd1);
    rp = p;
    rc = cout;
  endtask

  initial begin
    logic [W-1:0] rp, hold_p;
    logic         rc, hold_c;
    logic [W:0]   ref_sum;
    logic [W-1:0] ra, rb;
    int           prev_acc;

    vt[0] = '{24'hFFFFFF, 24'h000001, 24'h000000, 1'b1};
    vt[1] = '{24'h0000FF, 24'h000001, 24'h000100, 1'b0};
    vt[2] = '{24'h00FFFF, 24'h000001, 24'h010000, 1'b0};
    vt[3] = '{24'h123456, 24'h654321, 24'h777777, 1'b0};
    vt[4] = '{24'h800000, 24'h800000, 24'h000000, 1'b1};
    vt[5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b1};
    vt[6] = '{24'h00FF00, 24'h000100, 24'h010000, 1'b0};

    // Reset state
    #12;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_p",         {8'd0, p},          32'd0);
    check("rst_cout",      {31'd0, cout},      32'd0);
    check("rst_in_ready1", {31'd0, in_ready1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("rel_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_txn(vt[i].a, vt[i].b, 3, rp, rc);
      check($sformatf("vec%0d_p", i), {8'd0, rp}, {8'd0, vt[i].p});
      check($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vt[i].c});
    end

    // Backpressure: hold out_ready low for 5 cycles of out_valid
    @(negedge clk);
    out_ready = 1'b0;
    do_txn(24'h00ABCD, 24'h001111, 3, hold_p, hold_c);
    check("bp_p", {8'd0, hold_p}, 32'h0000BCDE);
    check("bp_cout", {31'd0, hold_c}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      a = 24'h5A5A5A;
      b = 24'hA5A5A5;
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      check("bp_p_stable",  {8'd0, p},          {8'd0, hold_p});
      check("bp_c_stable",  {31'd0, cout},      {31'd0, hold_c});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
    check("bp_release_p",         {8'd0, p},          32'h0000BCDE);

    // Reset during the second ADD cycle
    in_valid = 1'b1;
    a = 24'h0F0F0F;
    b = 24'h010101;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_p",         {8'd0, p},          32'd0);
    check("midrst_cout",      {31'd0, cout},      32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_rel_in_ready0", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_emit", {31'd0, out_valid}, 32'd0);
      check("midrst_idle_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_p_zero", {8'd0, p}, 32'd0);
    end
    do_txn(24'd5, 24'd7, 3, rp, rc);
    check("after_rst_p", {8'd0, rp}, 32'd12);
    check("after_rst_cout", {31'd0, rc}, 32'd0);

    // Back-to-back random traffic with out_ready held high
    prev_acc = -1;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 50 == 0) begin
        ra = '1;
        rb = W'(i + 1);
      end
      ref_sum = {1'b0, ra} + {1'b0, rb};
      do_txn(ra, rb, 3, rp, rc);
      check("rnd_p", {8'd0, rp}, {8'd0, ref_sum[W-1:0]});
      check("rnd_cout", {31'd0, rc}, {31'd0, ref_sum[W]});
      if (prev_acc >= 0) check("rnd_interval", last_acc - prev_acc, 5);
      prev_acc = last_acc;
    end

    // Single-chunk instance: latency 1
    @(negedge clk);
    check("c24_in_ready", {31'd0, in_ready1}, 32'd1);
    in_valid1 = 1'b1;
    a1 = 24'h800000;
    b1 = 24'h800000;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk);
    check("c24_not_yet", {31'd0, out_valid1}, 32'd0);
    @(negedge clk);
    check("c24_out_valid", {31'd0, out_valid1}, 32'd1);
    check("c24_p", {8'd0, p1}, 32'd0);
    check("c24_cout", {31'd0, cout1}, 32'd1);
    @(negedge clk);
    check("c24_idle_ready", {31'd0, in_ready1}, 32'd1);
    in_valid1 = 1'b1;
    a1 = 24'h123456;
    b1 = 24'h000BBB;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("c24_out_valid2", {31'd0, out_valid1}, 32'd1);
    check("c24_p2", {8'd0, p1}, 32'h00124011);
    check("c24_cout2", {31'd0, cout1}, 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
